// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer/consumer side uses the master view, the subtractor the slave view.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b - bin one bit per
// clock, LSB first, through a single full-subtractor cell.
// The sequence is accept (IDLE), WIDTH compute edges (BUSY), then the result
// is held until the consumer takes it (DONE).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             br;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             ovf_r;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             br_next;
   logic             last_bit;

   // Full-subtractor cell operating on the bit currently selected by cnt.
   always_comb begin
      a_bit    = a_r[cnt];
      b_bit    = b_r[cnt];
      d_bit    = a_bit ^ b_bit ^ br;
      br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, finish on the MSB, release on handshake.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_next = BUSY;
         BUSY:    if (last_bit)      state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture and serial result accumulation; the MSB step also
   // records the final borrow and the signed overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_r <= '0;
         bout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r    <= bus.a;
                  b_r    <= bus.b;
                  br     <= bus.bin;
                  cnt    <= '0;
                  diff_r <= '0;
                  bout_r <= 1'b0;
                  ovf_r  <= 1'b0;
               end
            end
            BUSY: begin
               diff_r[cnt] <= d_bit;
               br          <= br_next;
               cnt         <= cnt + CW'(1);
               if (last_bit) begin
                  bout_r <= br_next;
                  ovf_r  <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d_bit ^ a_r[WIDTH-1]);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.diff      = diff_r;
   assign bus.bout      = bout_r;
   assign bus.ovf       = ovf_r;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell (difference = a⊕b⊕br; borrow = (¬a·b) + (¬(a⊕b)·br)). It is the inverse-direction companion to the team's ripple adder datapath. It sits in the execute stage of the decode-and-execute lab and trades latency for a single arithmetic cell. Operands enter and the result leaves through valid/ready handshakes.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff, bout, ovf hold a completed result
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a − b − bin, mod 2^WIDTH
- bout  output  1  final borrow-out: 1 iff a < b + bin as unsigned values
- ovf  output  1  signed overflow: (a[MSB] ≠ b[MSB]) and (diff[MSB] ≠ a[MSB])

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Registers: a_r, b_r (WIDTH), br (1), cnt (clog2(WIDTH) bits), diff, bout, ovf.
- IDLE: in_ready=1. On an edge with in_valid=1, the block:
  - latches a, b, bin into a_r, b_r, br;
  - clears cnt, diff, bout and ovf;
  - moves to BUSY.
- BUSY: in_ready=0. Each edge:
  - diff[cnt] ← a_r[cnt]⊕b_r[cnt]⊕br;
  - br ← (¬a_r[cnt]·b_r[cnt]) + (¬(a_r[cnt]⊕b_r[cnt])·br);
  - cnt ← cnt+1.
- When cnt = WIDTH−1, that edge also does the following:
  - bout ← new borrow;
  - ovf ← computed from a_r[MSB], b_r[MSB] and the new diff[MSB];
  - the FSM moves to DONE.
- DONE: out_valid=1. diff, bout and ovf stay stable until handshake. On an edge with out_ready=1, the FSM moves to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE. Input operands may change freely after the accept edge.
- Arithmetic is pure mod 2^WIDTH. bin=1 with a=b yields diff = all ones and bout=1.
- Asynchronous reset (rst_n=0) forces the following in any state, including mid-BUSY:
  - FSM to IDLE;
  - diff=0, bout=0, ovf=0, out_valid=0;
  - in_ready=1 after release.
  - An in-flight operation is discarded and produces no out_valid pulse.

## Timing
- Reset values: in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
- Accept edge E0. BUSY occupies edges E1..E_WIDTH. out_valid rises after E_WIDTH, i.e. WIDTH+1 edges after acceptance (9 for WIDTH=8).
- out_valid stays high across any number of cycles with out_ready=0.
- Handshake edge with out_ready=1 → out_valid=0 and in_ready=1 in the next cycle.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH compute, 1 DONE).
- All outputs are registered. The design has no combinational path from any input to any output.
- diff bits fill LSB-first during BUSY. Consumers treat diff as valid only while out_valid=1.
- in_valid held high continuously yields back-to-back operations, each re-sampled in IDLE.

## Test plan
- Reset then WIDTH=8, a=0x05, b=0x03, bin=0 → out_valid after 9 edges, diff=0x02, bout=0, ovf=0; in_ready low throughout BUSY/DONE.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → diff/bout/ovf unchanged and out_valid held. Pulse in_valid during DONE with new operands → ignored. Raise out_ready → IDLE next cycle.
- Reset mid-op: assert rst_n=0 asynchronously at BUSY cycle 4 → outputs immediately zero, in_ready=1. After release, issue a=0xA5, b=0x5A, bin=0 → diff=0x4B, bout=0, ovf=1, with no stale result emitted.
- Back-to-back: in_valid and out_ready tied high with 16 random operand pairs → one result every 10 cycles, each matching a−b−bin against a behavioral model.
